// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 register file and exception sequencer:
// register indices, field positions, next-PC encodings and exception codes.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [1:0] {
        NPC_NORMAL  = 2'b00,
        NPC_HANDLER = 2'b01,
        NPC_EPC     = 2'b10
    } npc_sel_e;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] pack_sr(input sr_t s);
        logic [31:0] r;
        r                     = '0;
        r[SR_IM_HI:SR_IM_LO]  = s.im;
        r[SR_EXL_BIT]         = s.exl;
        r[SR_IE_BIT]          = s.ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input cause_t c);
        logic [31:0] r;
        r                           = '0;
        r[CAUSE_BD_BIT]             = c.bd;
        r[CAUSE_IP_HI:CAUSE_IP_LO]  = c.ip;
        r[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc;
        return r;
    endfunction

endpackage

// File: rtl/cp0_drain_cnt.sv
// Loadable 3-bit down-counter timing the post-take / post-eret flush window.
// done marks the last drain cycle (count == 1).
module cp0_drain_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [2:0] load_val,
    output logic [2:0] count,
    output logic       done
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign done = (count == 3'd1);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (SR/Cause/EPC/PRId) plus the RUN/DRAIN sequencer that
// takes interrupts/exceptions, handles eret and drives flush and next-PC.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID         = 32'h4755_4F59,
    parameter int unsigned FLUSH_CYC    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic        eret_M,
    input  logic        mtc0_we_M,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        Req,
    output logic        Flush,
    output logic [1:0]  NPC_sel,
    output logic [31:0] EPC_out
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);

    state_e      state;
    sr_t         sr;
    cause_t      cause;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        in_run;
    logic        take;
    logic        do_eret;
    logic        do_mtc0;
    logic        cnt_done;
    logic [2:0]  cnt_val;
    npc_sel_e    npc_sel;

    assign int_req = sr.ie & ~sr.exl & (|(HWInt & sr.im));
    assign exc_req = (ExcCode_M != EXC_INT) & ~sr.exl;
    assign in_run  = (state == ST_RUN);
    assign take    = in_run & (int_req | exc_req);
    // A take swallows any concurrent eret or mtc0 in the same cycle.
    assign do_eret = in_run & ~take & eret_M;
    assign do_mtc0 = in_run & ~take & mtc0_we_M;

    cp0_drain_cnt u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (take | do_eret),
        .en       (state == ST_DRAIN),
        .load_val (FLUSH_LOAD),
        .count    (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        npc_sel = NPC_NORMAL;
        if (take) begin
            npc_sel = NPC_HANDLER;
        end else if (do_eret) begin
            npc_sel = NPC_EPC;
        end
    end

    assign Req     = take;
    assign Flush   = take | do_eret | (state == ST_DRAIN);
    assign NPC_sel = npc_sel;
    assign EPC_out = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            sr    <= '0;
            cause <= '0;
            epc   <= '0;
        end else begin
            cause.ip <= HWInt;

            unique case (state)
                ST_RUN: begin
                    if (take || do_eret) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_done) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase

            if (take) begin
                sr.exl    <= 1'b1;
                cause.exc <= int_req ? EXC_INT : ExcCode_M;
                cause.bd  <= BD_M;
                epc       <= BD_M ? (PC_M - 32'd4) : PC_M;
            end else begin
                if (do_mtc0) begin
                    if (cp0_addr == CP0_SR) begin
                        sr.im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                        sr.exl <= cp0_wdata[SR_EXL_BIT];
                        sr.ie  <= cp0_wdata[SR_IE_BIT];
                    end else if (cp0_addr == CP0_EPC) begin
                        epc <= cp0_wdata;
                    end
                end
                // Placed after the mtc0 write so eret's EXL clear wins.
                if (do_eret) begin
                    sr.exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        unique case (cp0_addr)
            CP0_SR:    cp0_rdata = pack_sr(sr);
            CP0_CAUSE: cp0_rdata = pack_cause(cause);
            CP0_EPC:   cp0_rdata = epc;
            CP0_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = '0;
        endcase
    end

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID_V = 32'h4755_4F59;

    localparam int K_CTL = 0;
    localparam int K_RD  = 1;
    localparam int K_EPC = 2;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  ExcCode_M;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [5:0]  HWInt;
    logic        eret_M;
    logic        mtc0_we_M;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        Req;
    logic        Flush;
    logic [1:0]  NPC_sel;
    logic [31:0] EPC_out;

    exp_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    cp0_exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ExcCode_M (ExcCode_M),
        .PC_M      (PC_M),
        .BD_M      (BD_M),
        .HWInt     (HWInt),
        .eret_M    (eret_M),
        .mtc0_we_M (mtc0_we_M),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .Req       (Req),
        .Flush     (Flush),
        .NPC_sel   (NPC_sel),
        .EPC_out   (EPC_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged with the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    failures++;
                    $display("FAIL %s stale expectation from cycle %0d at cycle %0d", e.name, e.cyc, cyc);
                end else begin
                    case (e.kind)
                        K_CTL:   act = {28'd0, Req, Flush, NPC_sel};
                        K_RD:    act = cp0_rdata;
                        default: act = EPC_out;
                    endcase
                    if (act !== e.exp) begin
                        failures++;
                        $display("FAIL %s cycle %0d actual=%h required=%h", e.name, cyc, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic push(input int kind, input string nm, input logic [31:0] e);
        exp_t it;
        it.cyc  = cyc;
        it.kind = kind;
        it.name = nm;
        it.exp  = e;
        q.push_back(it);
    endtask

    // ctl encoding: {Req, Flush, NPC_sel}
    task automatic ctl(input logic [3:0] e, input string nm);
        push(K_CTL, nm, {28'd0, e});
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        cp0_addr = a;
        push(K_RD, nm, e);
    endtask

    task automatic epc_chk(input logic [31:0] e, input string nm);
        push(K_EPC, nm, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ExcCode_M = 5'd0;
        BD_M      = 1'b0;
        eret_M    = 1'b0;
        mtc0_we_M = 1'b0;
        cp0_wdata = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we_M = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        ExcCode_M = code;
        PC_M      = pc;
        BD_M      = bd;
    endtask

    initial begin
        reset = 1'b1; ExcCode_M = '0; PC_M = '0; BD_M = 1'b0; HWInt = '0;
        eret_M = 1'b0; mtc0_we_M = 1'b0; cp0_addr = '0; cp0_wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        ctl(4'b0000, "rst_ctl"); rd(5'd12, 32'h0, "rst_sr");    tick();
        ctl(4'b0000, "rst_ctl"); rd(5'd13, 32'h0, "rst_cause"); tick();
        ctl(4'b0000, "rst_ctl"); rd(5'd14, 32'h0, "rst_epc");   tick();
        ctl(4'b0000, "rst_ctl"); rd(5'd15, PRID_V, "rst_prid"); tick();
        ctl(4'b0000, "other_idx"); rd(5'd3, 32'h0, "rd_idx3");  tick();

        // Ov exception, not in delay slot
        mtc0(5'd12, 32'h0000_0001); ctl(4'b0000, "mtc0_sr"); tick();
        rd(5'd12, 32'h1, "sr_ie"); ctl(4'b0000, "idle"); tick();
        exc(5'd12, 32'h3010, 1'b0); ctl(4'b1101, "ov_take"); tick();
        ctl(4'b0100, "ov_drain"); rd(5'd14, 32'h3010, "ov_epc"); epc_chk(32'h3010, "ov_epc_out"); tick();
        ctl(4'b0000, "ov_run"); rd(5'd13, 32'h0000_0030, "ov_cause"); tick();
        ctl(4'b0000, "ov_idle"); rd(5'd12, 32'h3, "ov_sr_exl"); tick();

        // Masking while EXL=1
        mtc0(5'd12, 32'h0000_0403); ctl(4'b0000, "mtc0_im"); tick();
        exc(5'd5, 32'h3014, 1'b0); HWInt = 6'b000001;
        ctl(4'b0000, "mask_noreq"); rd(5'd12, 32'h403, "mask_sr"); tick();
        HWInt = 6'b000000;
        ctl(4'b0000, "mask_idle"); rd(5'd13, 32'h0000_0430, "mask_cause_ip"); tick();
        eret_M = 1'b1; ctl(4'b0110, "eret1"); epc_chk(32'h3010, "eret1_epc"); tick();
        ctl(4'b0100, "eret1_drain"); rd(5'd12, 32'h401, "eret1_sr"); tick();
        ctl(4'b0000, "eret1_run"); tick();

        // AdEL in delay slot
        exc(5'd4, 32'h3020, 1'b1); ctl(4'b1101, "bd_take"); tick();
        ctl(4'b0100, "bd_drain"); rd(5'd14, 32'h301C, "bd_epc"); tick();
        ctl(4'b0000, "bd_run"); rd(5'd13, 32'h8000_0010, "bd_cause"); tick();
        eret_M = 1'b1; ctl(4'b0110, "eret2"); epc_chk(32'h301C, "eret2_epc"); tick();
        ctl(4'b0100, "eret2_drain"); tick();
        ctl(4'b0000, "eret2_run"); rd(5'd12, 32'h401, "eret2_sr"); tick();

        // Interrupt beats RI in the same cycle
        mtc0(5'd12, 32'h0000_0401); ctl(4'b0000, "mtc0_sr2"); tick();
        HWInt = 6'b000001; exc(5'd10, 32'h3030, 1'b0); ctl(4'b1101, "int_take"); tick();
        ctl(4'b0100, "int_drain"); rd(5'd13, 32'h0000_0400, "int_cause"); tick();
        HWInt = 6'b000000;
        ctl(4'b0000, "int_run"); rd(5'd14, 32'h3030, "int_epc"); tick();
        ctl(4'b0000, "int_idle"); rd(5'd12, 32'h403, "int_sr"); tick();
        eret_M = 1'b1; ctl(4'b0110, "eret3"); epc_chk(32'h3030, "eret3_epc"); tick();

        // Interrupt raised during DRAIN is taken on the first RUN cycle
        HWInt = 6'b000001; ctl(4'b0100, "drain_pend"); tick();
        PC_M = 32'h3050; ctl(4'b1101, "pend_take"); tick();
        HWInt = 6'b000000; ctl(4'b0100, "pend_drain"); tick();
        ctl(4'b0000, "pend_run"); rd(5'd14, 32'h3050, "pend_epc"); tick();
        eret_M = 1'b1; ctl(4'b0110, "eret4"); tick();
        ctl(4'b0100, "eret4_drain"); tick();

        // mtc0 EPC concurrent with a take is discarded; mtc0 in DRAIN ignored
        mtc0(5'd14, 32'h5000); exc(5'd4, 32'h3040, 1'b0); ctl(4'b1101, "mtc0_take"); tick();
        mtc0(5'd14, 32'h7777); ctl(4'b0100, "mtc0_drain"); tick();
        ctl(4'b0000, "mtc0_run"); rd(5'd14, 32'h3040, "mtc0_epc_kept"); tick();

        // mtc0 SR with eret: write applies, EXL clear wins
        eret_M = 1'b1; mtc0(5'd12, 32'h0000_0C03);
        ctl(4'b0110, "eret_mtc0"); epc_chk(32'h3040, "eret5_epc"); tick();
        ctl(4'b0100, "eret5_drain"); rd(5'd12, 32'h0000_0C01, "eret_mtc0_sr"); tick();
        mtc0(5'd13, 32'hFFFF_FFFF); ctl(4'b0000, "mtc0_cause"); tick();
        ctl(4'b0000, "idle2"); rd(5'd13, 32'h0000_0010, "cause_unwritten"); tick();

        // Reset asserted in DRAIN
        exc(5'd12, 32'h3060, 1'b0); ctl(4'b1101, "rst_take"); tick();
        reset = 1'b1; ctl(4'b0100, "rst_in_drain"); tick();
        reset = 1'b0;
        ctl(4'b0000, "post_rst"); rd(5'd12, 32'h0, "post_rst_sr"); tick();
        ctl(4'b0000, "post_rst2"); rd(5'd13, 32'h0, "post_rst_cause"); tick();
        ctl(4'b0000, "post_rst3"); rd(5'd14, 32'h0, "post_rst_epc"); epc_chk(32'h0, "post_rst_epc_out"); tick();
        rd(5'd15, PRID_V, "post_rst_prid"); tick();

        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 register file plus exception/interrupt sequencer for the 5-stage MIPS CPU.
- Consumes the M-stage exception code produced by the exception pipeline, plus external hardware interrupts and M-stage eret/mtc0.
- Decides whether an exception, an interrupt or an eret is taken, updates SR/Cause/EPC, and drives pipeline flush and next-PC selection.
- Provides mfc0 read data.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC.
- PRID, 32'h4755_4F59, constant PRId value.
- FLUSH_CYC, 1, extra flush cycles after a take or eret; legal range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ExcCode_M  in  5  M-stage exception code; 0 means no exception
- PC_M  in  32  PC of the M-stage instruction
- BD_M  in  1  M-stage instruction is in a branch delay slot
- HWInt  in  6  external interrupt lines, level-sensitive
- eret_M  in  1  eret in M stage
- mtc0_we_M  in  1  mtc0 write in M stage
- cp0_addr  in  5  CP0 register index for read and write
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational
- Req  out  1  exception or interrupt taken this cycle
- Flush  out  1  nullify F/D/E/M pipeline registers
- NPC_sel  out  2  next-PC select: 00 normal, 01 HANDLER_ADDR, 10 EPC
- EPC_out  out  32  current EPC

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): constant PRID.
- Reads of any other index return 0.
- Cause.IP is loaded from HWInt on every clock, including while EXL=1.
- Reset: SR=0, Cause=0, EPC=0, FSM=RUN, counter=0. Outputs after reset: Req=0, Flush=0, NPC_sel=00.
- Take conditions:
  - int_req = IE & ~EXL & |(HWInt & IM).
  - exc_req = (ExcCode_M!=0) & ~EXL.
- FSM has two states, RUN and DRAIN.
- In RUN:
  - Priority is int_req > exc_req > eret_M.
  - Take (int or exc): Req=1, Flush=1, NPC_sel=01, all combinational in the same cycle.
  - At the edge after a take:
    - EXL<=1.
    - Cause.ExcCode<=0 for an interrupt, else ExcCode_M.
    - Cause.BD<=BD_M.
    - EPC<= BD_M ? PC_M-4 : PC_M, with 32-bit wrap.
    - Go to DRAIN with counter=FLUSH_CYC.
  - eret (no take): Req=0, Flush=1, NPC_sel=10 with EPC_out as the target. Next edge: EXL<=0, go to DRAIN.
  - mtc0_we_M with no take:
    - Writes SR (IM, EXL, IE fields only) or EPC.
    - Writes to Cause, PRId or other indices are ignored.
  - mtc0 in the same cycle as a take is discarded entirely.
  - mtc0 in the same cycle as eret applies, except that eret's EXL clear wins.
- In DRAIN:
  - Flush=1, Req=0, NPC_sel=00.
  - All requests, eret and mtc0 are ignored.
  - Counter decrements each cycle; go to RUN when it reaches 1.
  - Total Flush length after a take is therefore 1+FLUSH_CYC cycles.
- Reset asserted mid-DRAIN returns to RUN with all state cleared on that edge.
- ExcCode_M!=0 while EXL=1 is ignored; no nested exceptions.
- An interrupt that becomes pending during DRAIN is taken on the first RUN cycle in which it is still enabled.

Decomposition:
- Shared package holds:
  - CP0 register indices 12/13/14/15.
  - NPC_sel encodings.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- One sub-module, cp0_drain_cnt: loadable 3-bit down-counter with a done flag, used by the FSM.

Test Plan:
- Reset then idle:
  - Required: Req=0, Flush=0, NPC_sel=00, mfc0 12/13/14 read 0, mfc0 15 reads PRID.
- Exception, ExcCode_M=12, PC_M=0x3010, BD_M=0, IE=1 (Ov):
  - Same cycle: Req=1, NPC_sel=01.
  - Next cycle: EPC=0x3010, Cause[6:2]=12, EXL=1, Flush high for 2 cycles total.
- Exception in delay slot, ExcCode_M=4 with BD_M=1, PC_M=0x3020:
  - Required: EPC=0x301C, Cause.BD=1.
- Interrupt vs exception, mtc0 SR=0x0000_0401 then HWInt=6'b000001 with ExcCode_M=10 in the same cycle:
  - Required: interrupt taken, Cause.ExcCode=0, Cause.IP[10]=1.
- Masking:
  - Take an exception (EXL=1), then present ExcCode_M=5 and HWInt active → Req stays 0.
  - eret → NPC_sel=10 with EPC_out=EPC, then EXL=0.
- Simultaneous mtc0 and take:
  - mtc0 EPC=0x5000 in the same cycle as ExcCode_M=4, PC_M=0x3040 → EPC=0x3040; the mtc0 is discarded.
  - Reset asserted in DRAIN → Flush=0 next cycle and all CP0 registers read 0.
